// File: rtl/ysyx_25020037_axi_rd_slave_pkg.sv
// rtl/ysyx_25020037_axi_rd_slave_pkg.sv - AXI codes, FSM states and address helpers for the read slave
package ysyx_25020037_axi_rd_slave_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_FETCH,
    ST_DATA
  } rd_state_e;

  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

  // Reserved bursts step like INCR; their beats are SLVERR so the address is never used.
  function automatic logic [31:0] next_beat_addr(input logic [31:0] addr, input logic [7:0] len,
                                                 input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] step;
    logic [31:0] mask;
    step = 32'd1 << size;
    mask = ((32'(len) + 32'd1) << size) - 32'd1;
    case (burst)
      AXI_BURST_FIXED: return addr;
      AXI_BURST_WRAP:  return (addr & ~mask) | ((addr + step) & mask);
      default:         return addr + step;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_25020037_rd_sram.sv
// rtl/ysyx_25020037_rd_sram.sv - DEPTH x 32 word array, one sync read port, one write port
// A read and a write to the same word in one cycle returns the old contents.
module ysyx_25020037_rd_sram #(
  parameter int DEPTH = 1024,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata
);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_re) r_rdata <= r_mem[i_raddr];
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/ysyx_25020037_axi_rd_slave.sv
// rtl/ysyx_25020037_axi_rd_slave.sv - AXI4 AR/R responder over an on-chip word array
// One beat per FETCH/DATA pair: no prefetch, so every beat after the first costs one bubble.
module ysyx_25020037_axi_rd_slave
  import ysyx_25020037_axi_rd_slave_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = 32'h3000_0000,
  parameter int          DEPTH     = 1024,
  parameter int          RD_LAT    = 0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_arvalid,
  output logic        o_arready,
  input  logic [31:0] i_araddr,
  input  logic [3:0]  i_arid,
  input  logic [7:0]  i_arlen,
  input  logic [2:0]  i_arsize,
  input  logic [1:0]  i_arburst,
  output logic        o_rvalid,
  input  logic        i_rready,
  output logic [31:0] o_rdata,
  output logic [1:0]  o_rresp,
  output logic        o_rlast,
  output logic [3:0]  o_rid,
  input  logic        i_ld_wen,
  input  logic [31:0] i_ld_addr,
  input  logic [31:0] i_ld_wdata
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [32:0] SPAN = 33'(DEPTH) << 2;

  rd_state_e   r_state;
  logic [31:0] r_addr;
  logic [7:0]  r_len;
  logic [7:0]  r_beat_cnt;
  logic [2:0]  r_size;
  logic [1:0]  r_burst;
  logic [3:0]  r_lat_cnt;
  logic [3:0]  r_rid;
  logic        r_rvalid;
  logic        r_rlast;
  logic [1:0]  r_rresp;
  logic        r_rd_ok;

  logic [32:0] w_beat_off;
  logic [32:0] w_ld_off;
  logic        w_in_range;
  logic        w_bad_txn;
  logic [1:0]  w_beat_resp;
  logic        w_sram_re;
  logic        w_ld_we;
  logic        w_ar_hs;
  logic [31:0] w_sram_rdata;

  // 33-bit offsets: addresses below ADDR_BASE go negative and fail the range test.
  assign w_beat_off  = {1'b0, r_addr} - {1'b0, ADDR_BASE};
  assign w_ld_off    = {1'b0, i_ld_addr} - {1'b0, ADDR_BASE};
  assign w_in_range  = w_beat_off < SPAN;
  assign w_bad_txn   = (r_burst == 2'b11) || (r_size > 3'd2) ||
                       ((r_burst == AXI_BURST_WRAP) && !wrap_len_ok(r_len));
  assign w_beat_resp = w_bad_txn ? AXI_RESP_SLVERR :
                       !w_in_range ? AXI_RESP_DECERR : AXI_RESP_OKAY;
  assign w_sram_re   = (r_state == ST_FETCH) && (w_beat_resp == AXI_RESP_OKAY);
  assign w_ld_we     = i_ld_wen && (w_ld_off < SPAN);
  assign o_arready   = (r_state == ST_IDLE) && !i_rst;
  assign w_ar_hs     = i_arvalid && o_arready;

  ysyx_25020037_rd_sram #(.DEPTH(DEPTH)) u_sram (
    .i_clk   (i_clk),
    .i_re    (w_sram_re),
    .i_raddr (w_beat_off[AW+1:2]),
    .o_rdata (w_sram_rdata),
    .i_we    (w_ld_we),
    .i_waddr (w_ld_off[AW+1:2]),
    .i_wdata (i_ld_wdata)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_rvalid   <= 1'b0;
      r_rlast    <= 1'b0;
      r_rresp    <= AXI_RESP_OKAY;
      r_rd_ok    <= 1'b0;
      r_rid      <= 4'd0;
      r_beat_cnt <= 8'd0;
      r_lat_cnt  <= 4'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_ar_hs) begin
            r_addr     <= i_araddr;
            r_rid      <= i_arid;
            r_len      <= i_arlen;
            r_size     <= i_arsize;
            r_burst    <= i_arburst;
            r_beat_cnt <= 8'd0;
            if (RD_LAT > 0) begin
              r_lat_cnt <= 4'(RD_LAT - 1);
              r_state   <= ST_WAIT;
            end else begin
              r_state <= ST_FETCH;
            end
          end
        end
        ST_WAIT: begin
          if (r_lat_cnt == 4'd0) r_state <= ST_FETCH;
          else                   r_lat_cnt <= r_lat_cnt - 4'd1;
        end
        ST_FETCH: begin
          r_rvalid <= 1'b1;
          r_rresp  <= w_beat_resp;
          r_rd_ok  <= (w_beat_resp == AXI_RESP_OKAY);
          r_rlast  <= (r_beat_cnt == r_len);
          r_state  <= ST_DATA;
        end
        ST_DATA: begin
          if (i_rready) begin
            r_rvalid <= 1'b0;
            r_rlast  <= 1'b0;
            if (r_rlast) begin
              r_state <= ST_IDLE;
            end else begin
              r_beat_cnt <= r_beat_cnt + 8'd1;
              r_addr     <= next_beat_addr(r_addr, r_len, r_size, r_burst);
              r_state    <= ST_FETCH;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // The array output register only moves on a read, so rdata holds through DATA stalls.
  assign o_rdata  = r_rd_ok ? w_sram_rdata : 32'd0;
  assign o_rvalid = r_rvalid;
  assign o_rlast  = r_rlast;
  assign o_rresp  = r_rresp;
  assign o_rid    = r_rid;

endmodule

// File: tb/tb_ysyx_25020037_axi_rd_slave.sv
// tb/tb_ysyx_25020037_axi_rd_slave.sv - table-driven and randomized bench for the AXI read slave
module tb_ysyx_25020037_axi_rd_slave;

  localparam logic [31:0] BASE   = 32'h3000_0000;
  localparam int          DEPTH  = 64;
  localparam int          RD_LAT = 3;
  localparam logic [31:0] TOP    = BASE + 32'(4 * DEPTH);

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  id;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    int          mode;
    logic [1:0]  resp0;
  } vec_t;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_arvalid = 1'b0;
  logic        o_arready;
  logic [31:0] i_araddr = '0;
  logic [3:0]  i_arid = '0;
  logic [7:0]  i_arlen = '0;
  logic [2:0]  i_arsize = '0;
  logic [1:0]  i_arburst = '0;
  logic        o_rvalid;
  logic        i_rready = 1'b0;
  logic [31:0] o_rdata;
  logic [1:0]  o_rresp;
  logic        o_rlast;
  logic [3:0]  o_rid;
  logic        i_ld_wen = 1'b0;
  logic [31:0] i_ld_addr = '0;
  logic [31:0] i_ld_wdata = '0;

  int n_vec = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [31:0] mem_m [DEPTH];
  vec_t tbl [11];

  always #5 clk = ~clk;

  ysyx_25020037_axi_rd_slave #(.ADDR_BASE(BASE), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_arvalid(i_arvalid), .o_arready(o_arready), .i_araddr(i_araddr), .i_arid(i_arid),
    .i_arlen(i_arlen), .i_arsize(i_arsize), .i_arburst(i_arburst),
    .o_rvalid(o_rvalid), .i_rready(i_rready), .o_rdata(o_rdata), .o_rresp(o_rresp),
    .o_rlast(o_rlast), .o_rid(o_rid),
    .i_ld_wen(i_ld_wen), .i_ld_addr(i_ld_addr), .i_ld_wdata(i_ld_wdata)
  );

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Beat i address from the burst rules: start, start + i*step, or modulo the wrap window.
  function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [7:0] len,
                                            input logic [2:0] size, input logic [1:0] burst,
                                            input int i);
    longint step, bnd, lo;
    step = longint'(1) << size;
    bnd  = (longint'(len) + 1) * step;
    case (burst)
      2'd0:    return a;
      2'd2: begin
        lo = longint'(a) - (longint'(a) % bnd);
        return 32'(lo + ((longint'(a) - lo + i * step) % bnd));
      end
      default: return 32'(longint'(a) + i * step);
    endcase
  endfunction

  function automatic logic [1:0] exp_resp(input logic [31:0] a, input logic [7:0] len,
                                          input logic [2:0] size, input logic [1:0] burst);
    if (burst == 2'd3 || size > 3'd2 ||
        (burst == 2'd2 && !(len == 1 || len == 3 || len == 7 || len == 15)))
      return 2'b10;
    if (a < BASE || a >= TOP) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [31:0] exp_data(input logic [31:0] a, input logic [1:0] resp);
    if (resp != 2'b00) return 32'd0;
    return mem_m[int'((a - BASE) >> 2)];
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    tick();
    i_ld_wen = 1'b1; i_ld_addr = a; i_ld_wdata = d;
    tick();
    i_ld_wen = 1'b0;
    if (a >= BASE && a < TOP) mem_m[int'((a - BASE) >> 2)] = d;
  endtask

  // mode 0: rready always high, 1: random rready, 2: hold rready low 4 cycles on beat 2
  task automatic run_burst(input vec_t v);
    int hs, prev, beat, waited, stalls;
    logic first, rr;
    logic [31:0] held, a, ed;
    logic [1:0] er;
    tick();
    i_arvalid = 1'b1; i_araddr = v.addr; i_arid = v.id; i_arlen = v.len;
    i_arsize = v.size; i_arburst = v.burst;
    chk("arready_idle", 32'(o_arready), 32'd1);
    hs = cyc; prev = hs; beat = 0; waited = 0; stalls = 0; first = 1'b1; held = '0;
    while (beat <= int'(v.len)) begin
      tick();
      waited++;
      i_arvalid = 1'b0;
      if (waited > 1000) begin
        n_vec++; n_fail++;
        $display("FAIL beat_timeout: got beat %0d of %0d, required all beats", beat, int'(v.len) + 1);
        break;
      end
      if (v.mode == 0)      rr = 1'b1;
      else if (v.mode == 1) rr = ($urandom_range(0, 3) != 0);
      else                  rr = !(beat == 2 && o_rvalid && stalls < 4);
      if (v.mode == 2 && !rr) stalls++;
      i_rready = rr;
      if (o_rvalid) begin
        if (first) begin
          chk("rvalid_latency", 32'(cyc), 32'(beat == 0 ? hs + 2 + RD_LAT : prev + 2));
          held = o_rdata;
          first = 1'b0;
        end else begin
          chk("rdata_hold", o_rdata, held);
          chk("arready_busy", 32'(o_arready), 32'd0);
        end
        if (rr) begin
          a  = beat_addr(v.addr, v.len, v.size, v.burst, beat);
          er = exp_resp(a, v.len, v.size, v.burst);
          ed = exp_data(a, er);
          chk("rdata", o_rdata, ed);
          chk("rresp", 32'(o_rresp), 32'(er));
          chk("rlast", 32'(o_rlast), 32'(beat == int'(v.len)));
          chk("rid", 32'(o_rid), 32'(v.id));
          if (beat == 0) chk("rresp_beat0", 32'(o_rresp), 32'(v.resp0));
          prev = cyc;
          beat++;
          first = 1'b1;
        end
      end
    end
    tick();
    i_rready = 1'b0;
    chk("rvalid_after_last", 32'(o_rvalid), 32'd0);
    chk("arready_after_last", 32'(o_arready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, w;
    logic [7:0] lens [6];
    vec_t rv;
    lens = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd7, 8'd15};
    tbl[0]  = '{BASE + 32'd4,  4'd5,  8'd0, 3'd2, 2'd0, 0, 2'b00};
    tbl[1]  = '{BASE,          4'd1,  8'd3, 3'd2, 2'd1, 0, 2'b00};
    tbl[2]  = '{BASE,          4'd2,  8'd3, 3'd2, 2'd1, 2, 2'b00};
    tbl[3]  = '{BASE + 32'd8,  4'd3,  8'd3, 3'd2, 2'd2, 0, 2'b00};
    tbl[4]  = '{BASE + 32'd8,  4'd4,  8'd2, 3'd2, 2'd2, 0, 2'b10};
    tbl[5]  = '{TOP - 32'd4,   4'd6,  8'd1, 3'd2, 2'd1, 0, 2'b00};
    tbl[6]  = '{BASE + 32'd1,  4'd7,  8'd0, 3'd0, 2'd0, 0, 2'b00};
    tbl[7]  = '{32'hFFFF_FFFC, 4'd8,  8'd1, 3'd2, 2'd1, 0, 2'b11};
    tbl[8]  = '{BASE,          4'd9,  8'd1, 3'd2, 2'd3, 0, 2'b10};
    tbl[9]  = '{BASE,          4'd10, 8'd0, 3'd3, 2'd1, 0, 2'b10};
    tbl[10] = '{BASE - 32'd4,  4'd11, 8'd0, 3'd2, 2'd0, 0, 2'b11};

    repeat (3) tick();
    chk("reset_rvalid", 32'(o_rvalid), 32'd0);
    chk("reset_rlast", 32'(o_rlast), 32'd0);
    chk("reset_rresp", 32'(o_rresp), 32'd0);
    chk("reset_rdata", o_rdata, 32'd0);
    chk("reset_rid", 32'(o_rid), 32'd0);
    chk("reset_arready", 32'(o_arready), 32'd0);
    i_rst = 1'b0;

    preload(BASE,          32'h11);
    preload(BASE + 32'd4,  32'h22);
    preload(BASE + 32'd8,  32'h33);
    preload(BASE + 32'd12, 32'h44);
    preload(BASE + 32'd16, 32'h55);
    preload(TOP - 32'd4,   32'hDEAD_BEEF);
    preload(TOP,           32'hBAD0_BAD0);

    for (int i = 0; i < 11; i++) run_burst(tbl[i]);

    // Preload write to the word being fetched in the same cycle: read sees the old value.
    tick();
    i_arvalid = 1'b1; i_araddr = BASE + 32'd16; i_arid = 4'd12; i_arlen = 8'd0;
    i_arsize = 3'd2; i_arburst = 2'd0;
    w = cyc;
    tick();
    i_arvalid = 1'b0;
    while (cyc < w + 1 + RD_LAT) tick();
    i_ld_wen = 1'b1; i_ld_addr = BASE + 32'd16; i_ld_wdata = 32'h6666_6666;
    tick();
    i_ld_wen = 1'b0; i_rready = 1'b1;
    chk("rbw_rvalid", 32'(o_rvalid), 32'd1);
    chk("rbw_old_data", o_rdata, 32'h55);
    mem_m[4] = 32'h6666_6666;
    tick();
    i_rready = 1'b0;
    run_burst('{BASE + 32'd16, 4'd13, 8'd0, 3'd2, 2'd0, 0, 2'b00});

    // Reset pulse while beat 1 of a 4-beat burst is on the bus.
    tick();
    i_arvalid = 1'b1; i_araddr = BASE; i_arid = 4'd14; i_arlen = 8'd3;
    i_arsize = 3'd2; i_arburst = 2'd1; i_rready = 1'b1;
    cnt = 0; w = 0;
    while (w < 100) begin
      tick();
      w++;
      i_arvalid = 1'b0;
      if (o_rvalid) begin
        cnt++;
        if (cnt == 2) break;
      end
    end
    chk("rst_reached_beat1", 32'(cnt), 32'd2);
    i_rready = 1'b0;
    i_rst = 1'b1;
    tick();
    chk("rst_rvalid", 32'(o_rvalid), 32'd0);
    chk("rst_arready_low", 32'(o_arready), 32'd0);
    i_rst = 1'b0;
    #1;
    chk("post_rst_arready", 32'(o_arready), 32'd1);
    run_burst('{BASE + 32'd12, 4'd15, 8'd0, 3'd2, 2'd0, 0, 2'b00});

    for (int k = 0; k < DEPTH; k++) preload(BASE + 32'(4 * k), $urandom);
    for (int n = 0; n < 40; n++) begin
      rv.addr  = BASE - 32'd16 + 32'($urandom_range(0, 4 * DEPTH + 32));
      rv.id    = 4'($urandom_range(0, 15));
      rv.len   = lens[$urandom_range(0, 5)];
      rv.size  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      rv.burst = 2'($urandom_range(0, 3));
      rv.mode  = 1;
      rv.resp0 = exp_resp(rv.addr, rv.len, rv.size, rv.burst);
      run_burst(rv);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
